// File: rtl/joy_pos_tracker.sv
// ---------------------------------------------------------------------------
// joy_pos_tracker
//   Converts raw joystick SPI frames into a clamped sprite position. The
//   position advances once per VGA frame: a frame_tick in IDLE snapshots the
//   latest stick reading, STEP_X updates pos_x, and STEP_Y updates pos_y and
//   pulses update_done.
//
//   Optional feature: define JOY_DEADZONE_EN to force an axis velocity to 0
//   while |raw - 512| < DZ. The default build (macro undefined) has no
//   deadzone.
//
// Ports
//   clk             in   system clock, rising edge
//   clr             in   synchronous active-high reset (wins over all inputs)
//   jstk_data[39:0] in   raw joystick frame
//   data_valid      in   one-cycle pulse, jstk_data holds a new frame
//   frame_tick      in   one-cycle pulse at VGA frame start
//   pos_x[9:0]      out  sprite X, registered
//   pos_y[9:0]      out  sprite Y, registered
//   btn_left_pulse  out  one-cycle pulse on left-button press
//   btn_right_pulse out  one-cycle pulse on right-button press
//   update_done     out  one-cycle pulse after both axes are updated
//   state_dbg[1:0]  out  FSM state (0 IDLE, 1 STEP_X, 2 STEP_Y)
//
// Handshake: data_valid and frame_tick are single-cycle strobes with no
// back-pressure; data_valid is accepted in every state, frame_tick only in
// IDLE (ignored otherwise).
// ---------------------------------------------------------------------------
module joy_pos_tracker #(
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 623,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 463,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int DZ     = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [39:0] jstk_data,
  input  logic        data_valid,
  input  logic        frame_tick,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        btn_left_pulse,
  output logic        btn_right_pulse,
  output logic        update_done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2
  } state_t;

  state_t state, state_nx;

  logic       snap_en, step_x_en, step_y_en;
  logic [9:0] raw_x, raw_y;
  logic       raw_left, raw_right;
  logic [9:0] latest_x, latest_y;
  logic       latest_left, latest_right;
  logic [9:0] snap_x, snap_y;
  logic signed [3:0]  vel_x, vel_y;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0] next_x, next_y;

  // Frame field decode; the remaining frame bits carry nothing we use.
  assign raw_x     = {jstk_data[25:24], jstk_data[39:32]};
  assign raw_y     = {jstk_data[9:8],   jstk_data[23:16]};
  assign raw_left  = jstk_data[2];
  assign raw_right = jstk_data[1];

  logic unused_bits;
  assign unused_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:3], jstk_data[0]};

`ifndef JOY_DEADZONE_EN
  localparam int unused_dz = DZ;
`endif

  // Velocity: centre-relative offset divided by 128 with floor, -4..+3.
  function automatic logic signed [3:0] axis_vel(input logic [9:0] raw);
    logic signed [10:0] off;
    off = $signed({1'b0, raw}) - 11'sd512;
`ifdef JOY_DEADZONE_EN
    if (int'(off) > -DZ && int'(off) < DZ) return 4'sd0;
`endif
    return 4'(off >>> 7);
  endfunction

  // Saturate a signed sum into [lo, hi]; never wraps.
  function automatic logic [9:0] clamp_pos(input logic signed [11:0] s,
                                           input int lo, input int hi);
    if (int'(s) < lo) return 10'(lo);
    if (int'(s) > hi) return 10'(hi);
    return s[9:0];
  endfunction

  assign vel_x  = axis_vel(snap_x);
  assign vel_y  = axis_vel(snap_y);
  assign sum_x  = $signed({2'b00, pos_x}) + $signed({{8{vel_x[3]}}, vel_x});
  // Stick up means larger raw_y, but screen Y grows downward.
  assign sum_y  = $signed({2'b00, pos_y}) - $signed({{8{vel_y[3]}}, vel_y});
  assign next_x = clamp_pos(sum_x, X_MIN, X_MAX);
  assign next_y = clamp_pos(sum_y, Y_MIN, Y_MAX);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_tick) state_nx = STEP_X;
      STEP_X:  state_nx = STEP_Y;
      STEP_Y:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs (datapath enables)
  always_comb begin
    snap_en   = 1'b0;
    step_x_en = 1'b0;
    step_y_en = 1'b0;
    case (state)
      IDLE:    snap_en   = frame_tick;
      STEP_X:  step_x_en = 1'b1;
      STEP_Y:  step_y_en = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // Datapath. The snapshot reads latest_* before this edge's data_valid
  // update lands, so a coincident frame uses the previous reading.
  always_ff @(posedge clk) begin
    if (clr) begin
      pos_x           <= 10'(X_INIT);
      pos_y           <= 10'(Y_INIT);
      btn_left_pulse  <= 1'b0;
      btn_right_pulse <= 1'b0;
      update_done     <= 1'b0;
      latest_x        <= 10'd512;
      latest_y        <= 10'd512;
      latest_left     <= 1'b0;
      latest_right    <= 1'b0;
      snap_x          <= 10'd512;
      snap_y          <= 10'd512;
    end else begin
      btn_left_pulse  <= data_valid & raw_left  & ~latest_left;
      btn_right_pulse <= data_valid & raw_right & ~latest_right;
      update_done     <= 1'b0;
      if (data_valid) begin
        latest_x     <= raw_x;
        latest_y     <= raw_y;
        latest_left  <= raw_left;
        latest_right <= raw_right;
      end
      if (snap_en) begin
        snap_x <= latest_x;
        snap_y <= latest_y;
      end
      if (step_x_en) pos_x <= next_x;
      if (step_y_en) begin
        pos_y       <= next_y;
        update_done <= 1'b1;
      end
    end
  end

endmodule
